// File: rtl/fabric_error_collector.sv
// N-source fabric error aggregator: sticky first-error record plus saturating event counter.
// Optional history FIFO of {src, code} per event cycle, enabled by FABRIC_ERROR_HIST_EN.

module fec_src_qual #(
    parameter int CODE_W = 16
) (
    input  logic              vld,
    input  logic [CODE_W-1:0] code,
    output logic              ev
);
    // Code 0 is FABRIC_OK; a valid pulse carrying it is not an error.
    assign ev = vld && (code != '0);
endmodule

module fabric_error_collector #(
    parameter int NUM_SRC    = 4,
    parameter int CODE_W     = 16,
    parameter int CNT_W      = 8,
    parameter int HIST_DEPTH = 4,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_err_valid,
    input  logic [NUM_SRC*CODE_W-1:0] src_err_code,
    input  logic                      err_clear,
    output logic                      err_valid,
    output logic [CODE_W-1:0]         err_code,
    output logic [SRC_W-1:0]          err_src,
    output logic                      err_is_rt,
    output logic [CNT_W-1:0]          err_count,
    output logic                      hist_valid,
    input  logic                      hist_ready,
    output logic [SRC_W+CODE_W-1:0]   hist_data,
    output logic                      hist_overflow
);
    localparam int POP_W = $clog2(NUM_SRC + 1);
    localparam int SUM_W = CNT_W + POP_W + 1;
    localparam int RT_W  = CODE_W + 9;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, LATCHED} state_t;

    state_t              state, state_nxt;
    logic [NUM_SRC-1:0]  ev;
    logic                any_ev;
    logic [SRC_W-1:0]    win_src;
    logic [CODE_W-1:0]   win_code;
    logic                win_rt;
    logic [POP_W-1:0]    ev_pop;
    logic [CNT_W-1:0]    cnt_base, cnt_nxt;
    logic [SUM_W-1:0]    cnt_sum;
    logic                rec_load, rec_zero;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fec_src_qual #(.CODE_W(CODE_W)) u_qual (
            .vld  (src_err_valid[gi]),
            .code (src_err_code[gi*CODE_W +: CODE_W]),
            .ev   (ev[gi])
        );
    end

    // Descending scan so the lowest qualified index is the last write and wins.
    always_comb begin
        win_src  = '0;
        win_code = '0;
        ev_pop   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (ev[i]) begin
                win_src  = SRC_W'(i);
                win_code = src_err_code[i*CODE_W +: CODE_W];
            end
        end
        for (int i = 0; i < NUM_SRC; i++)
            ev_pop = ev_pop + POP_W'(ev[i]);
    end

    assign any_ev = |ev;
    assign win_rt = RT_W'(win_code) >= RT_W'(256);

    // Clear zeroes the base before this cycle's events are added.
    always_comb begin
        cnt_base = err_clear ? '0 : err_count;
        cnt_sum  = SUM_W'(cnt_base) + SUM_W'(ev_pop);
        cnt_nxt  = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        rec_load  = 1'b0;
        rec_zero  = 1'b0;
        case (state)
            IDLE: begin
                if (any_ev) begin
                    state_nxt = LATCHED;
                    rec_load  = 1'b1;
                end
            end
            LATCHED: begin
                if (err_clear) begin
                    if (any_ev) begin
                        rec_load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        rec_zero  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            err_code  <= '0;
            err_src   <= '0;
            err_is_rt <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            err_count <= cnt_nxt;
            if (rec_load) begin
                err_code  <= win_code;
                err_src   <= win_src;
                err_is_rt <= win_rt;
            end else if (rec_zero) begin
                err_code  <= '0;
                err_src   <= '0;
                err_is_rt <= 1'b0;
            end
        end
    end

    assign err_valid = (state == LATCHED);

`ifdef FABRIC_ERROR_HIST_EN
    localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int HW    = SRC_W + CODE_W;

    logic [HW-1:0]    hist_mem [HIST_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   hist_cnt;
    logic             hist_full, hist_pop, hist_push, hist_drop;

    assign hist_full  = (hist_cnt == (PTR_W+1)'(HIST_DEPTH));
    assign hist_pop   = hist_valid && hist_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign hist_push  = any_ev && (!hist_full || hist_pop);
    assign hist_drop  = any_ev && hist_full && !hist_pop;
    assign hist_valid = (hist_cnt != '0);
    assign hist_data  = hist_valid ? hist_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (hist_push)
            hist_mem[wr_ptr] <= {win_src, win_code};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            hist_cnt      <= '0;
            hist_overflow <= 1'b0;
        end else begin
            if (hist_push) wr_ptr <= wr_ptr + 1'b1;
            if (hist_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({hist_push, hist_pop})
                2'b10:   hist_cnt <= hist_cnt + 1'b1;
                2'b01:   hist_cnt <= hist_cnt - 1'b1;
                default: hist_cnt <= hist_cnt;
            endcase
            hist_overflow <= (hist_overflow && !err_clear) || hist_drop;
        end
    end
`else
    logic unused_hist;
    assign unused_hist   = hist_ready | (HIST_DEPTH < 2);
    assign hist_valid    = 1'b0;
    assign hist_data     = '0;
    assign hist_overflow = 1'b0;
`endif

`ifdef FABRIC_ASSERTIONS_ON
    a_hist_stable: assert property (@(posedge clk) disable iff (rst)
        (hist_valid && !hist_ready) |=> $stable(hist_data));
    a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
        !err_clear |=> (err_count >= $past(err_count)));
`endif

endmodule
